// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-requester front end for an SDRAM controller with one outstanding transaction,
// round-robin on ties and a read-response timeout.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] m0_addr,
  input  logic        m0_rw,
  input  logic [7:0]  m0_din,
  input  logic        m0_in_valid,
  output logic        m0_busy,
  output logic [7:0]  m0_dout,
  output logic        m0_out_valid,
  input  logic [22:0] m1_addr,
  input  logic        m1_rw,
  input  logic [7:0]  m1_din,
  input  logic        m1_in_valid,
  output logic        m1_busy,
  output logic [7:0]  m1_dout,
  output logic        m1_out_valid,
  output logic [22:0] s_addr,
  output logic        s_rw,
  output logic [7:0]  s_din,
  output logic        s_in_valid,
  input  logic        s_busy,
  input  logic [7:0]  s_dout,
  input  logic        s_out_valid,
  output logic        rd_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t r_state, w_next;
  logic [1:0][22:0] w_in_addr, r_addr;
  logic [1:0][7:0]  w_in_din, r_din, r_dout;
  logic [1:0]       w_in_rw, w_in_valid, r_rw, r_full, r_ov;
  logic             r_sel, r_last, w_pick, w_issue, w_done, w_expire;
  logic [15:0]      r_cnt;
  logic [16:0]      w_cnt_inc;
  logic [22:0]      r_s_addr;
  logic [7:0]       r_s_din;
  logic             r_s_rw, r_s_iv, r_to;
  assign w_in_addr  = {m1_addr, m0_addr};
  assign w_in_din   = {m1_din, m0_din};
  assign w_in_rw    = {m1_rw, m0_rw};
  assign w_in_valid = {m1_in_valid, m0_in_valid};
  assign {m1_busy, m0_busy}           = r_full;
  assign {m1_out_valid, m0_out_valid} = r_ov;
  assign m0_dout    = r_dout[0];
  assign m1_dout    = r_dout[1];
  assign s_addr     = r_s_addr;
  assign s_rw       = r_s_rw;
  assign s_din      = r_s_din;
  assign s_in_valid = r_s_iv;
  assign rd_timeout = r_to;
  always_comb begin
    w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    // requester 1 wins when it alone is full, or on a tie when requester 0 was served last
    w_pick    = r_full[1] & (~r_full[0] | ~r_last);
    w_issue   = (r_state == ISSUE) && !s_busy;
    w_done    = (r_state == RD_WAIT) && s_out_valid;
    w_expire  = (r_state == RD_WAIT) && !s_out_valid && (w_cnt_inc == 17'(TIMEOUT_CYCLES));
    w_next    = (r_state == IDLE)  ? (|r_full ? ISSUE : IDLE) :
                (r_state == ISSUE) ? (s_busy ? ISSUE : (r_rw[r_sel] ? IDLE : RD_WAIT)) :
                (r_state == RD_WAIT) ? ((w_done || w_expire) ? IDLE : RD_WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= '0;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_cnt    <= '0;
      r_s_addr <= '0;
      r_s_rw   <= 1'b0;
      r_s_din  <= '0;
      r_s_iv   <= 1'b0;
      r_dout   <= '0;
      r_ov     <= '0;
      r_to     <= 1'b0;
    end else begin
      r_s_iv <= w_issue;
      r_ov   <= w_done ? (2'b01 << r_sel) : 2'b00;
      r_to   <= w_expire;
      if (r_state == IDLE) r_sel <= w_pick;
      if (w_issue) begin
        r_s_addr <= r_addr[r_sel];
        r_s_rw   <= r_rw[r_sel];
        r_s_din  <= r_din[r_sel];
        r_last   <= r_sel;
        r_cnt    <= '0;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_done) r_dout[r_sel] <= s_dout;
      // a full buffer never captures, so capture and drain of one buffer cannot collide
      for (int i = 0; i < 2; i++) begin
        if (w_in_valid[i] && !r_full[i]) begin
          r_full[i] <= 1'b1;
          r_addr[i] <= w_in_addr[i];
          r_rw[i]   <= w_in_rw[i];
          r_din[i]  <= w_in_din[i];
        end else if (w_issue && r_sel == i[0]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model of the arbiter.
module tb_sdram_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic [22:0] in_addr [2];
  logic        in_rw [2];
  logic [7:0]  in_din [2];
  logic        in_iv [2];
  logic [1:0]       o_busy, o_ov;
  logic [1:0][7:0]  o_dout;
  logic [22:0] s_addr;
  logic        s_rw, s_in_valid, s_busy, s_out_valid, rd_timeout;
  logic [7:0]  s_din, s_dout;
  int checks = 0, errors = 0;

  sdram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(in_addr[0]), .m0_rw(in_rw[0]), .m0_din(in_din[0]), .m0_in_valid(in_iv[0]),
    .m0_busy(o_busy[0]), .m0_dout(o_dout[0]), .m0_out_valid(o_ov[0]),
    .m1_addr(in_addr[1]), .m1_rw(in_rw[1]), .m1_din(in_din[1]), .m1_in_valid(in_iv[1]),
    .m1_busy(o_busy[1]), .m1_dout(o_dout[1]), .m1_out_valid(o_ov[1]),
    .s_addr(s_addr), .s_rw(s_rw), .s_din(s_din), .s_in_valid(s_in_valid), .s_busy(s_busy),
    .s_dout(s_dout), .s_out_valid(s_out_valid), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: buffers, a pending selection and the age of an outstanding read.
  bit          armed = 0;
  bit          e_full [2];
  logic [22:0] b_addr [2];
  bit          b_rw [2];
  logic [7:0]  b_din [2];
  int          sel = -1, rd_age = -1, owner = 0;
  bit          last = 1;
  logic [22:0] e_saddr;
  logic        e_srw, e_siv, e_to;
  logic [7:0]  e_sdin;
  logic [7:0]  e_dout [2];
  logic        e_ov [2];

  always @(posedge clk) begin
    bit cap [2];
    if (rst) begin
      armed = 1;
      sel = -1; rd_age = -1; last = 1;
      e_saddr = 0; e_srw = 0; e_sdin = 0; e_siv = 0; e_to = 0;
      for (int i = 0; i < 2; i++) begin e_full[i] = 0; e_dout[i] = 0; e_ov[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin cap[i] = in_iv[i] && !e_full[i]; e_ov[i] = 0; end
      e_to = 0; e_siv = 0;
      if (rd_age >= 0) begin
        if (s_out_valid) begin e_dout[owner] = s_dout; e_ov[owner] = 1; rd_age = -1; end
        else if (rd_age + 1 == TO) begin e_to = 1; rd_age = -1; end
        else rd_age++;
      end else if (sel >= 0) begin
        if (!s_busy) begin
          e_saddr = b_addr[sel]; e_srw = b_rw[sel]; e_sdin = b_din[sel]; e_siv = 1;
          e_full[sel] = 0; last = sel[0];
          if (!b_rw[sel]) begin rd_age = 0; owner = sel; end
          sel = -1;
        end
      end else if (e_full[0] || e_full[1]) begin
        sel = (e_full[0] && e_full[1]) ? (last ? 0 : 1) : (e_full[0] ? 0 : 1);
      end
      for (int i = 0; i < 2; i++)
        if (cap[i]) begin
          e_full[i] = 1; b_addr[i] = in_addr[i]; b_rw[i] = in_rw[i]; b_din[i] = in_din[i];
        end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m0_busy", o_busy[0], e_full[0]);
      chk("m1_busy", o_busy[1], e_full[1]);
      chk("m0_out_valid", o_ov[0], e_ov[0]);
      chk("m1_out_valid", o_ov[1], e_ov[1]);
      chk("m0_dout", o_dout[0], e_dout[0]);
      chk("m1_dout", o_dout[1], e_dout[1]);
      chk("s_in_valid", s_in_valid, e_siv);
      chk("s_addr", s_addr, e_saddr);
      chk("s_rw", s_rw, e_srw);
      chk("s_din", s_din, e_sdin);
      chk("rd_timeout", rd_timeout, e_to);
    end
  end

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin in_iv[i] = 0; in_rw[i] = 0; in_addr[i] = 0; in_din[i] = 0; end
    s_busy = 0; s_out_valid = 0; s_dout = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic req(input int m, input bit rw, input logic [22:0] a, input logic [7:0] d);
    in_iv[m] = 1; in_rw[m] = rw; in_addr[m] = a; in_din[m] = d;
  endtask

  task automatic wait_siv();
    int n = 0;
    @(negedge clk);
    while (s_in_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("s_in_valid_seen", s_in_valid, 1);
  endtask

  initial begin
    do_reset();
    chk("reset_busy", o_busy, 2'b00);
    chk("reset_saddr", s_addr, 0);
    chk("reset_siv", s_in_valid, 0);
    // single write: busy for two cycles, issue in the third
    req(0, 1, 23'h008000, 8'hA5);
    @(negedge clk); in_iv[0] = 0;
    chk("wr_busy1", o_busy[0], 1);
    @(negedge clk);
    chk("wr_busy2", o_busy[0], 1);
    chk("wr_siv_early", s_in_valid, 0);
    @(negedge clk);
    chk("wr_siv", s_in_valid, 1);
    chk("wr_addr", s_addr, 23'h008000);
    chk("wr_rw", s_rw, 1);
    chk("wr_din", s_din, 8'hA5);
    chk("wr_busy_clr", o_busy[0], 0);
    @(negedge clk);
    chk("wr_siv_pulse", s_in_valid, 0);
    chk("wr_addr_hold", s_addr, 23'h008000);
    // tie after reset: m0 first, each read answered on its own port
    do_reset();
    req(0, 0, 23'h000100, 8'h00); req(1, 0, 23'h000200, 8'h00);
    @(negedge clk); in_iv[0] = 0; in_iv[1] = 0;
    wait_siv();
    chk("tie_first", s_addr, 23'h000100);
    s_out_valid = 1; s_dout = 8'h11;
    @(negedge clk); s_out_valid = 0;
    chk("tie_m0_ov", o_ov, 2'b01);
    chk("tie_m0_dout", o_dout[0], 8'h11);
    wait_siv();
    chk("tie_second", s_addr, 23'h000200);
    s_out_valid = 1; s_dout = 8'h22;
    @(negedge clk); s_out_valid = 0;
    chk("tie_m1_ov", o_ov, 2'b10);
    chk("tie_m1_dout", o_dout[1], 8'h22);
    chk("tie_m0_dout_kept", o_dout[0], 8'h11);
    // back-pressure: held in ISSUE, new m0 strobes ignored
    do_reset();
    s_busy = 1;
    req(0, 1, 23'h001234, 8'h3C);
    @(negedge clk);
    req(0, 1, 23'h000999, 8'h77);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_no_siv", s_in_valid, 0);
      chk("bp_busy", o_busy[0], 1);
    end
    s_busy = 0;
    @(negedge clk); in_iv[0] = 0;
    chk("bp_siv", s_in_valid, 1);
    chk("bp_addr", s_addr, 23'h001234);
    chk("bp_din", s_din, 8'h3C);
    // timeout on m0 read, then pending m1 write goes out
    do_reset();
    req(0, 0, 23'h000040, 8'h00); req(1, 1, 23'h000050, 8'h66);
    @(negedge clk); in_iv[0] = 0; in_iv[1] = 0;
    wait_siv();
    chk("to_addr", s_addr, 23'h000040);
    repeat (3) begin @(negedge clk); chk("to_early", rd_timeout, 0); end
    @(negedge clk);
    chk("to_pulse", rd_timeout, 1);
    chk("to_no_ov", o_ov, 2'b00);
    wait_siv();
    chk("to_next_addr", s_addr, 23'h000050);
    chk("to_next_rw", s_rw, 1);
    // reset while waiting for read data, late response dropped
    do_reset();
    req(0, 0, 23'h000777, 8'h00);
    @(negedge clk); in_iv[0] = 0;
    wait_siv();
    rst = 1;
    @(negedge clk); rst = 0;
    s_out_valid = 1; s_dout = 8'h5A;
    @(negedge clk); s_out_valid = 0;
    chk("rr_ov", o_ov, 2'b00);
    chk("rr_dout", {o_dout[1], o_dout[0]}, 0);
    chk("rr_saddr", s_addr, 0);
    chk("rr_to", rd_timeout, 0);
    // fairness under continuous writes
    do_reset();
    req(0, 1, 23'h0000A0, 8'h01); req(1, 1, 23'h0000B0, 8'h02);
    for (int k = 0; k < 4; k++) begin
      wait_siv();
      chk("fair_order", s_addr, (k % 2) ? 23'h0000B0 : 23'h0000A0);
    end
    in_iv[0] = 0; in_iv[1] = 0;
    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        req(i, 1'($urandom), 23'($urandom), 8'($urandom));
      in_iv[0] = ($urandom_range(0, 2) == 0);
      in_iv[1] = ($urandom_range(0, 2) == 0);
      s_busy = ($urandom_range(0, 3) == 0);
      s_out_valid = ($urandom_range(0, 5) == 0);
      s_dout = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of RD_WAIT cycles before a read is abandoned (range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have per requester x in {0,1} these ports:
- mx_addr, input, 23 bits: address.
- mx_rw, input, 1 bit: 1 = write, 0 = read.
- mx_din, input, 8 bits: write data.
- mx_in_valid, input, 1 bit: request strobe.
- mx_busy, output, 1 bit: request buffer full.
- mx_dout, output, 8 bits: read data.
- mx_out_valid, output, 1 bit: read-data strobe.
REQ-005 SHALL have these SDRAM-controller-side ports:
- s_addr, output, 23 bits.
- s_rw, output, 1 bit.
- s_din, output, 8 bits.
- s_in_valid, output, 1 bit.
- s_busy, input, 1 bit.
- s_dout, input, 8 bits.
- s_out_valid, input, 1 bit.
REQ-006 SHALL have port rd_timeout, output, 1 bit: one-cycle pulse when a read is abandoned.

Function
REQ-007 SHALL hold a one-entry buffer per requester capturing {addr, rw, din} when mx_in_valid=1 and mx_busy=0; mx_busy SHALL equal the buffer-full flag (registered).
REQ-008 SHALL ignore mx_in_valid while mx_busy=1, including the cycle in which that buffer is being drained (no capture, no error).
REQ-009 SHALL implement states IDLE, ISSUE and RD_WAIT.
REQ-010 IDLE: if exactly one buffer is full, SHALL select it; if both are full, SHALL select the requester other than last_grant; then go to ISSUE. No full buffer: stay in IDLE.
REQ-011 ISSUE: when s_busy=0, SHALL on the next edge:
- load s_addr/s_rw/s_din from the selected buffer and assert s_in_valid for exactly one cycle;
- clear that buffer;
- set last_grant = selected requester;
- go to IDLE if the request is a write, or to RD_WAIT with the timeout counter cleared if it is a read.
REQ-012 ISSUE with s_busy=1 SHALL hold state and outputs, with s_in_valid=0.
REQ-013 RD_WAIT with s_out_valid=1 SHALL on the next edge load mx_dout of the selected requester with s_dout, pulse mx_out_valid for one cycle, and go to IDLE; the other requester's dout/out_valid SHALL be unchanged/0.
REQ-014 RD_WAIT: the counter SHALL increment each cycle with s_out_valid=0; on reaching TIMEOUT_CYCLES it SHALL pulse rd_timeout for one cycle, assert no mx_out_valid, and go to IDLE.
REQ-015 s_out_valid in IDLE or ISSUE SHALL be discarded (no out_valid, no state change).
REQ-016 s_out_valid on the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority: data is delivered and rd_timeout=0.
REQ-017 Minimum latency from capture edge (mx_in_valid sampled) to s_in_valid high SHALL be 3 cycles with s_busy=0; read data SHALL reach mx_out_valid 1 cycle after s_out_valid.
REQ-018 At most one SDRAM transaction SHALL be outstanding; a new issue SHALL NOT occur before a read completes or times out.
REQ-019 s_addr/s_rw/s_din SHALL hold their last issued values between issues.

Reset
REQ-020 rst=1 SHALL force:
- state IDLE; both buffers empty; last_grant = 1 (so m0 wins the first tie);
- s_addr=0, s_rw=0, s_din=0, s_in_valid=0;
- mx_busy=0, mx_dout=0, mx_out_valid=0, rd_timeout=0, timeout counter 0.
REQ-021 Reset mid-operation SHALL drop pending and outstanding requests; a late s_out_valid after reset SHALL be discarded per REQ-015.

Verification
REQ-022 Single write, s_busy=0: m0 write addr 0x008000 data 0xA5 -> s_in_valid high 3 cycles later for one cycle with s_addr=0x008000, s_rw=1, s_din=0xA5; m0_busy high for 2 cycles.
REQ-023 Tie: m0 and m1 reads captured on the same edge after reset -> m0 issued first, m1 second; each gets its own s_dout (0x11, then 0x22) with out_valid only on its own port.
REQ-024 Back-pressure: s_busy=1 for 10 cycles while in ISSUE -> no s_in_valid; issue occurs on the edge after s_busy falls; m0_in_valid during that time is ignored (m0_busy=1).
REQ-025 Timeout: TIMEOUT_CYCLES=4, read issued, no s_out_valid -> rd_timeout pulse after 4 RD_WAIT cycles, no m-port out_valid, next pending request then issued.
REQ-026 Reset in RD_WAIT followed by s_out_valid=1 with s_dout=0x5A -> all outputs at reset values, no out_valid.
REQ-027 Fairness: both requesters continuously requesting writes -> issues alternate m0, m1, m0, m1.
